// File: rtl/pattern_tx_1101.sv
// Serial frame transmitter: sync 1101, DATA_W payload bits MSB first, even parity, guard bit.
// Every output is a flop whose next value is decoded from the next state, not from inputs.
module pattern_tx_1101 #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] data,
    output logic              ready,
    output logic              out,
    output logic              valid,
    output logic              done
);

    // The counter also sequences the four sync bits, so it never drops below 2 bits.
    localparam int unsigned CntW = ($clog2(DATA_W) > 2) ? $clog2(DATA_W) : 2;
    localparam logic [CntW-1:0] SyncLast = CntW'(3);
    localparam logic [CntW-1:0] DataLast = CntW'(DATA_W - 1);
    localparam logic [3:0] SyncPat = 4'b1011; // bit i is the i-th sync bit sent

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StSync  = 3'd1,
        StData  = 3'd2,
        StPar   = 3'd3,
        StGuard = 3'd4
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic              par_q, par_d;
    logic              out_q, out_d;
    logic              valid_q, valid_d;
    logic              ready_q, ready_d;
    logic              done_q, done_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            shreg_q <= '0;
            par_q   <= 1'b0;
            out_q   <= 1'b0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            par_q   <= par_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            ready_q <= ready_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        par_d   = par_q;
        done_d  = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StSync;
                    cnt_d   = '0;
                    shreg_d = data;
                    par_d   = ^data;
                end
            end
            StSync: begin
                if (cnt_q == SyncLast) begin
                    state_d = StData;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StData: begin
                if (cnt_q == DataLast) begin
                    state_d = StPar;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CntW'(1);
                    shreg_d = {shreg_q[DATA_W-2:0], 1'b0};
                end
            end
            StPar: begin
                state_d = StGuard;
                cnt_d   = '0;
            end
            StGuard: begin
                state_d = StIdle;
                cnt_d   = '0;
                done_d  = 1'b1;
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
                shreg_d = '0;
                par_d   = 1'b0;
            end
        endcase
    end

    always_comb begin
        out_d   = 1'b0;
        valid_d = 1'b0;
        ready_d = 1'b0;
        case (state_d)
            StIdle: ready_d = 1'b1;
            StSync: begin
                valid_d = 1'b1;
                out_d   = SyncPat[cnt_d[1:0]];
            end
            StData: begin
                valid_d = 1'b1;
                out_d   = shreg_d[DATA_W-1];
            end
            StPar: begin
                valid_d = 1'b1;
                out_d   = par_d;
            end
            default: ;
        endcase
    end

    assign ready = ready_q;
    assign out   = out_q;
    assign valid = valid_q;
    assign done  = done_q;

endmodule

// File: tb/tb_pattern_tx_1101.sv
// Bench for pattern_tx_1101: table-driven frames, multi-cycle corner sequences, loopback
// detector, and a randomized run against a queue-based frame model.
module tb_pattern_tx_1101;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [DW-1:0] data = '0;
    logic          ready, tx_out, valid, done;
    logic [3:0]    obs;

    int n_checks = 0;
    int n_err    = 0;

    pattern_tx_1101 #(.DATA_W(DW)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .data  (data),
        .ready (ready),
        .out   (tx_out),
        .valid (valid),
        .done  (done)
    );

    always #5 clk = ~clk;

    assign obs = {tx_out, valid, ready, done};

    // Loopback Moore 1101 detector.
    logic [3:0] hist = 4'b0000;
    logic       det  = 1'b0;
    int         det_cnt = 0;
    always @(posedge clk) begin
        if (det) det_cnt <= det_cnt + 1;
        hist <= {hist[2:0], tx_out};
        det  <= ({hist[2:0], tx_out} == 4'b1101);
    end

    // Model: a queue of future per-cycle observations {out, valid, ready, done}.
    logic [3:0] mq[$];
    logic [3:0] mcur = 4'b0010;

    task automatic model_edge(input logic st, input logic [DW-1:0] d);
        logic [3:0] sb;
        sb = 4'b1101;
        if (mq.size() == 0 && st) begin
            for (int i = 3; i >= 0; i--) mq.push_back({sb[i], 3'b100});
            for (int i = DW - 1; i >= 0; i--) mq.push_back({d[i], 3'b100});
            mq.push_back({^d, 3'b100});
            mq.push_back(4'b0000);
            mq.push_back(4'b0011);
        end
        if (mq.size() != 0) mcur = mq.pop_front();
        else mcur = 4'b0010;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [DW-1:0] d;
        logic [13:0]   eo;
    } vec_t;
    vec_t tbl[6];
    logic [13:0] vpat;

    // Sends one frame from IDLE and checks all 14 output cycles plus the done cycle.
    task automatic run_frame(input logic [DW-1:0] d, input logic [13:0] eo, input string tag);
        start = 1'b1;
        data  = d;
        step();
        start = 1'b0;
        data  = DW'($urandom);
        for (int c = 1; c <= 14; c++) begin
            chk($sformatf("%s_c%0d", tag, c), {28'd0, obs}, {28'd0, eo[14-c], vpat[14-c], 2'b00});
            step();
        end
        chk($sformatf("%s_done", tag), {28'd0, obs}, 32'h3);
        step();
        chk($sformatf("%s_after", tag), {28'd0, obs}, 32'h2);
    endtask

    initial begin
        int dones;
        int det0;
        logic [3:0] sb;
        logic [13:0] a5;
        logic r;

        vpat = 14'b11111111111110;
        sb   = 4'b1101;
        a5   = 14'b1101_10100101_0_0;
        tbl[0] = '{d: 8'hA5, eo: 14'b1101_10100101_0_0};
        tbl[1] = '{d: 8'h07, eo: 14'b1101_00000111_1_0};
        tbl[2] = '{d: 8'h00, eo: 14'b1101_00000000_0_0};
        tbl[3] = '{d: 8'hFF, eo: 14'b1101_11111111_0_0};
        tbl[4] = '{d: 8'h3C, eo: 14'b1101_00111100_0_0};
        tbl[5] = '{d: 8'h01, eo: 14'b1101_00000001_1_0};

        // Reset state, asynchronous and across edges with start requested.
        #2 rst = 1'b1;
        start = 1'b1;
        #1 chk("reset_async", {28'd0, obs}, 32'h2);
        step();
        step();
        chk("reset_held", {28'd0, obs}, 32'h2);
        rst   = 1'b0;
        start = 1'b0;
        step();
        chk("idle_no_start", {28'd0, obs}, 32'h2);

        foreach (tbl[k]) run_frame(tbl[k].d, tbl[k].eo, $sformatf("tbl%0d", k));

        // start held high: back-to-back frames, ready only in cycles 0 and 15.
        start = 1'b1;
        data  = 8'h3C;
        chk("b2b_ready_c0", {31'd0, ready}, 32'd1);
        for (int c = 1; c <= 19; c++) begin
            step();
            chk($sformatf("b2b_ready_c%0d", c), {31'd0, ready}, {31'd0, (c == 15)});
            if (c >= 16) chk($sformatf("b2b_sync_c%0d", c), {31'd0, tx_out}, {31'd0, sb[19-c]});
        end
        start = 1'b0;
        dones = 0;
        for (int c = 0; c < 40 && dones == 0; c++) begin
            step();
            if (done) dones++;
        end
        chk("b2b_second_done", dones, 1);
        step();

        // Ignored starts and data change during an active frame.
        start = 1'b1;
        data  = 8'hA5;
        step();
        start = 1'b0;
        dones = 0;
        for (int c = 1; c <= 14; c++) begin
            chk($sformatf("busy_c%0d", c), {31'd0, tx_out}, {31'd0, a5[14-c]});
            start = (c == 3 || c == 9);
            if (c == 5) data = 8'hFF;
            step();
            if (done) dones++;
        end
        start = 1'b0;
        for (int c = 15; c <= 30; c++) begin
            step();
            if (done) dones++;
        end
        chk("busy_one_done", dones, 1);
        chk("busy_idle_after", {28'd0, obs}, 32'h2);

        // Asynchronous reset in the middle of cycle 7.
        start = 1'b1;
        data  = 8'hA5;
        step();
        start = 1'b0;
        for (int c = 1; c < 7; c++) step();
        #2 rst = 1'b1;
        start = 1'b1;
        #1 chk("midrst_async", {28'd0, obs}, 32'h2);
        step();
        chk("midrst_held", {28'd0, obs}, 32'h2);
        rst   = 1'b0;
        start = 1'b0;
        dones = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (done) dones++;
        end
        chk("midrst_no_done", dones, 0);
        run_frame(8'hA5, a5, "after_rst");

        // Loopback: two back-to-back all-zero frames give exactly two detections.
        for (int c = 0; c < 4; c++) step();
        det0  = det_cnt;
        start = 1'b1;
        data  = 8'h00;
        for (int c = 1; c <= 16; c++) begin
            step();
            if (c == 16) start = 1'b0;
        end
        for (int c = 0; c < 25; c++) step();
        chk("loopback_detections", det_cnt - det0, 2);

        // Randomized run against the model.
        rst = 1'b1;
        mq.delete();
        mcur = 4'b0010;
        step();
        rst = 1'b0;
        for (int it = 0; it < 800; it++) begin
            r     = ($urandom_range(0, 59) == 0);
            start = ($urandom_range(0, 3) == 0);
            data  = DW'($urandom);
            if (r) begin
                #2 rst = 1'b1;
                #1;
                mq.delete();
                mcur = 4'b0010;
                chk($sformatf("rand_rst_%0d", it), {28'd0, obs}, {28'd0, mcur});
            end
            step();
            if (rst) rst = 1'b0;
            else model_edge(start, data);
            chk($sformatf("rand_%0d", it), {28'd0, obs}, {28'd0, mcur});
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
